spi_read_master: RTL and testbench
==================================

// Module: spi_read_master
// PURPOSE
// - SPI master that issues 8-bit register reads to the SPI slave register bank (register addresses 1..8).
// - Sends an 8-bit address on mosi, then captures 8 data bits from miso. Both are LSB first.
// - Generates sck, ss and mosi from the system clock.
// - Sits between a host FSM (start/addr/rdata/done handshake) and the off-block SPI bus.
// PARAMETERS
// - CLK_DIV  2  clk cycles per sck half-period. Legal range 1..255; the counter is 8 bits.
// PORTS
// - clk    in   1  system clock; all logic on posedge.
// - reset  in   1  synchronous, active-high reset.
// - start  in   1  request pulse; accepted only when busy=0.
// - addr   in   8  register address; latched on accept.
// - cpol   in   1  sck idle level; latched on accept.
// - cpoh   in   1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
// - busy   out  1  high from the cycle after accept until done.
// - done   out  1  one-cycle pulse; rdata valid in the same cycle.
// - rdata  out  8  read data; holds its value until the next done.
// - err    out  1  one-cycle pulse on a rejected address (SPI_READ_MASTER_ADDR_CHECK_EN only; else tied 0).
// - sck    out  1  SPI clock.
// - ss     out  1  slave select, active HIGH.
// - mosi   out  1  master-out data.
// - miso   in   1  slave-out data. May be z/x outside the data phase; ignored there.
// BEHAVIOUR
// - Reset (sync, overrides everything, including mid-transfer abort):
//   - state=IDLE, sck=0, ss=0, mosi=0, busy=0, done=0, err=0, rdata=8'h00, all counters=0.
//   - After reset, sck idles at the cpol value seen in IDLE.
// - States:
//   - IDLE: sck follows cpol; ss=0. start=1 in cycle T -> latch addr/cpol/cpoh, go to SETUP.
//     From T+1: busy=1, ss=1, mosi=addr[0].
//   - SETUP: hold for CLK_DIV cycles, then go to SHIFT.
//   - SHIFT: 32 sck half-periods of CLK_DIV cycles each = 16 sck cycles, bit index b = 0..15.
//     - Toggle sck at the end of every half-period; the first toggle is the leading edge of b=0.
//     - b=0..7: drive mosi = addr[b].
//     - b=8..15: mosi=0; sample miso into shift[b-8] on the sampling edge.
//     - cpoh=0: sample on the leading edge; mosi changes on the trailing edge (bit 0 was preset in SETUP).
//     - cpoh=1: mosi changes on the leading edge; sample on the trailing edge.
//     - After the 32nd toggle, sck is back at the latched cpol. Go to HOLD.
//   - HOLD: hold for CLK_DIV cycles, then go to DONE.
//   - DONE: one cycle. ss=0, busy=0, done=1, rdata=shift. Go to IDLE.
// - Latency: start at cycle T -> done at T + 34*CLK_DIV + 1. A new start is accepted in the cycle after done.
// - Ignored inputs:
//   - start while busy=1 is ignored; no queueing.
//   - cpol/cpoh/addr changes while busy=1 have no effect.
// - Half-period counter: counts 0..CLK_DIV-1 and wraps to 0 on each toggle. Bit counter: 5 bits, 0..31 half-periods.
// - ss never toggles mid-transfer. sck never glitches: exactly 32 edges per transfer.
// CONFIGURATION
// - SPI_READ_MASTER_ADDR_CHECK_EN defined:
//   - start with addr outside 8'h01..8'h08 -> err=1 in cycle T+1.
//   - No bus activity: ss stays 0, busy stays 0, done stays 0, rdata unchanged.
// - Not defined: every address is issued on the bus; err is tied to 0.
// TESTING
// - Reset: assert reset mid-SHIFT -> next cycle ss=0, busy=0, sck=0, rdata=8'h00; a fresh start then completes normally.
// - Mode 0 (cpol=0, cpoh=0), CLK_DIV=2, addr=8'h03, slave bank reg3=8'hA5:
//   - mosi LSB-first 1,1,0,0,0,0,0,0; exactly 16 sck rising edges.
//   - rdata=8'hA5 with done at T+69.
// - Mode 3 (cpol=1, cpoh=1), addr=8'h08, reg8=8'h3C:
//   - sck idles high before and after; sampling on rising (trailing) edges.
//   - rdata=8'h3C.
// - Back-to-back: second start in the cycle after done, addr=8'h01 then 8'h02 -> both reads correct.
//   - A start pulsed mid-transfer is ignored (exactly one done per accepted start).
// - Addr check (macro on): addr=8'h00 and 8'h09 -> err pulse at T+1, ss never rises.
//   - Macro off: addr=8'h09 runs a full 16-bit transfer.
// - CLK_DIV=1 edge case: sck period = 2 clk cycles, done at T+35, data correct in all four cpol/cpoh modes.

Source files
------------

// File: rtl/spi_read_master.sv
// SPI read master: sends an 8-bit address LSB first on mosi, then captures 8 data bits LSB first from miso.
// Latency: start accepted in cycle T -> done pulse (with rdata) at T + 34*CLK_DIV + 1.
// Backpressure: none; start is ignored while busy. Optional macro SPI_READ_MASTER_ADDR_CHECK_EN rejects addresses outside 1..8.
module spi_read_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic       cpol,
    input  logic       cpoh,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err,
    output logic       sck,
    output logic       ss,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] half_q, half_d;
    logic [7:0] addr_q, addr_d;
    logic       pol_q, pol_d;
    logic       pha_q, pha_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rdata_q, rdata_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       ss_q, ss_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       cnt_end;
    logic [2:0] bit_idx;
    logic [2:0] nxt_idx;
    logic       addr_ok;

    assign cnt_end = (cnt_q == DIV_LAST);
    // Half-period h belongs to bit h/2; even h ends on a leading edge, odd h on a trailing edge.
    assign bit_idx = half_q[3:1];
    assign nxt_idx = bit_idx + 3'd1;

`ifdef SPI_READ_MASTER_ADDR_CHECK_EN
    assign addr_ok = (addr >= 8'h01) && (addr <= 8'h08);
`else
    assign addr_ok = 1'b1;
`endif

    // Next-state and datapath decode; every register holds unless its state updates it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        addr_d  = addr_q;
        pol_d   = pol_q;
        pha_d   = pha_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                sck_d  = cpol;
                mosi_d = 1'b0;
                cnt_d  = 8'd0;
                half_d = 5'd0;
                if (start) begin
                    if (addr_ok) begin
                        state_d = S_SETUP;
                        addr_d  = addr;
                        pol_d   = cpol;
                        pha_d   = cpoh;
                        mosi_d  = addr[0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_end) begin
                    cnt_d   = 8'd0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_end) begin
                    cnt_d  = 8'd0;
                    sck_d  = ~sck_q;
                    half_d = half_q + 5'd1;
                    if (!half_q[0]) begin
                        // Leading edge: phase 1 launches mosi, phase 0 samples miso.
                        if (pha_q) begin
                            mosi_d = half_q[4] ? 1'b0 : addr_q[bit_idx];
                        end else if (half_q[4]) begin
                            shift_d[bit_idx] = miso;
                        end
                    end else begin
                        // Trailing edge: phase 0 launches the next bit, phase 1 samples miso.
                        if (!pha_q) begin
                            mosi_d = (half_q[4] || bit_idx == 3'd7) ? 1'b0 : addr_q[nxt_idx];
                        end else if (half_q[4]) begin
                            shift_d[bit_idx] = miso;
                        end
                    end
                    if (half_q == 5'd31) begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_end) begin
                    cnt_d   = 8'd0;
                    state_d = S_DONE;
                    rdata_d = shift_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ss_d   = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; synchronous reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            half_q  <= 5'd0;
            addr_q  <= 8'd0;
            pol_q   <= 1'b0;
            pha_q   <= 1'b0;
            shift_q <= 8'd0;
            rdata_q <= 8'd0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ss_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            addr_q  <= addr_d;
            pol_q   <= pol_d;
            pha_q   <= pha_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ss_q    <= ss_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy  = ss_q;
    assign ss    = ss_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign sck   = sck_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_read_master.sv
// Testbench for spi_read_master: two instances (CLK_DIV=2 and CLK_DIV=1) each talking to a behavioural SPI slave bank.
// Latency: checks done at T+69 (CLK_DIV=2) and T+35 (CLK_DIV=1).
// Backpressure: exercises ignored starts while busy and back-to-back starts after done.
module tb_spi_read_master;

    logic       clk;
    logic       reset;
    logic [1:0] start_v;
    logic [7:0] addr_s;
    logic       cpol_s;
    logic       cpoh_s;
    logic [1:0] busy_v, done_v, err_v, sck_v, ss_v, mosi_v, miso_v;
    logic [7:0] rdata0, rdata1;

    int errors = 0;
    int checks = 0;

    // Slave model state, one slot per DUT
    int         edges [2];
    int         rises [2];
    logic [7:0] cap   [2];
    logic       pha_s [2];
    logic [1:0] ss_prev, sck_prev;
    int         sb;
    logic       slead, ssamp;
    logic [7:0] sd;
    int         err_cnt = 0;

    spi_read_master #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .addr(addr_s), .cpol(cpol_s), .cpoh(cpoh_s),
        .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata0), .err(err_v[0]),
        .sck(sck_v[0]), .ss(ss_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0])
    );

    spi_read_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .addr(addr_s), .cpol(cpol_s), .cpoh(cpoh_s),
        .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata1), .err(err_v[1]),
        .sck(sck_v[1]), .ss(ss_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bank(input logic [7:0] a);
        case (a)
            8'h01: bank = 8'h81;
            8'h02: bank = 8'h42;
            8'h03: bank = 8'hA5;
            8'h04: bank = 8'h24;
            8'h05: bank = 8'h99;
            8'h06: bank = 8'h66;
            8'h07: bank = 8'hC3;
            8'h08: bank = 8'h3C;
            default: bank = 8'h5A;
        endcase
    endfunction

    // Behavioural slave: counts sck edges while selected, captures the address, returns bank data.
    always @(sck_v or ss_v) begin
        for (int i = 0; i < 2; i++) begin
            if (ss_v[i] === 1'b1 && ss_prev[i] !== 1'b1) begin
                edges[i]  = 0;
                rises[i]  = 0;
                cap[i]    = 8'h00;
                miso_v[i] = 1'bx;
            end else if (ss_v[i] === 1'b1 && sck_v[i] !== sck_prev[i]) begin
                edges[i] = edges[i] + 1;
                sb       = (edges[i] - 1) / 2;
                slead    = (edges[i] % 2) == 1;
                ssamp    = pha_s[i] ? !slead : slead;
                if (sck_v[i] === 1'b1) rises[i] = rises[i] + 1;
                if (ssamp && sb < 8) cap[i][sb] = mosi_v[i];
                if (!pha_s[i] && !slead && sb >= 7 && sb <= 14) begin
                    sd = bank(cap[i]);
                    miso_v[i] = sd[sb - 7];
                end
                if (pha_s[i] && slead && sb >= 8 && sb <= 15) begin
                    sd = bank(cap[i]);
                    miso_v[i] = sd[sb - 8];
                end
            end
            ss_prev[i]  = ss_v[i];
            sck_prev[i] = sck_v[i];
        end
    end

    always @(negedge clk) if (err_v[0] === 1'b1) err_cnt = err_cnt + 1;

    task automatic set_mode(input logic pol, input logic pha);
        cpol_s = pol;
        cpoh_s = pha;
        repeat (2) @(negedge clk);
    endtask

    // Issue one read on DUT i (caller is at a negedge); returns data and cycles from accept to done.
    task automatic do_read(input int i, input logic [7:0] a, input logic mid,
                           output logic [7:0] rd, output int lat);
        logic pol0, pha0;
        int n;
        pol0     = cpol_s;
        pha0     = cpoh_s;
        pha_s[i] = cpoh_s;
        addr_s   = a;
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
        n = 1;
        while (done_v[i] !== 1'b1 && n < 300) begin
            if (mid && n == 20) begin
                start_v[i] = 1'b1;
                addr_s = 8'h07;
                cpol_s = ~pol0;
                cpoh_s = ~pha0;
            end else if (mid && n == 21) begin
                start_v[i] = 1'b0;
                addr_s = a;
                cpol_s = pol0;
                cpoh_s = pha0;
            end
            @(negedge clk);
            n++;
        end
        if (done_v[i] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d addr=%h: no done after %0d cycles", i, a, n);
        end
        lat = n;
        rd  = (i == 0) ? rdata0 : rdata1;
    endtask

    task automatic test_reset;
        logic [7:0] rd;
        int lat;
        reset = 1'b1; start_v = 2'b00; addr_s = 8'h00; cpol_s = 1'b0; cpoh_s = 1'b0;
        pha_s[0] = 1'b0; pha_s[1] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sck_v[0], ss_v[0], busy_v[0], done_v[0], err_v[0], mosi_v[0]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got sck/ss/busy/done/err/mosi=%b want 000000",
                     {sck_v[0], ss_v[0], busy_v[0], done_v[0], err_v[0], mosi_v[0]});
        end
        checks++;
        if (rdata0 !== 8'h00) begin
            errors++; $display("FAIL reset_rdata got %h want 00", rdata0);
        end
        reset = 1'b0;
        @(negedge clk);
        do_read(0, 8'h04, 1'b0, rd, lat);
        checks++;
        if (rd !== 8'h24) begin errors++; $display("FAIL pre_abort_read got %h want 24", rd); end
        @(negedge clk);
        set_mode(1'b1, 1'b0);
        pha_s[0] = 1'b0;
        addr_s = 8'h06;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy_v[0]); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ss_v[0], busy_v[0], sck_v[0]} !== 3'b000 || rdata0 !== 8'h00) begin
            errors++;
            $display("FAIL abort_reset got ss/busy/sck=%b rdata=%h want 000 rdata=00",
                     {ss_v[0], busy_v[0], sck_v[0]}, rdata0);
        end
        reset = 1'b0;
        set_mode(1'b0, 1'b0);
        do_read(0, 8'h05, 1'b0, rd, lat);
        checks++;
        if (rd !== 8'h99 || lat !== 69) begin
            errors++; $display("FAIL after_reset_read got rdata=%h lat=%0d want 99 lat=69", rd, lat);
        end
    endtask

    task automatic test_mode0;
        logic [7:0] rd;
        int lat;
        @(negedge clk);
        set_mode(1'b0, 1'b0);
        do_read(0, 8'h03, 1'b0, rd, lat);
        checks++;
        if (rd !== 8'hA5) begin errors++; $display("FAIL mode0_rdata got %h want a5", rd); end
        checks++;
        if (lat !== 69) begin errors++; $display("FAIL mode0_latency got %0d want 69", lat); end
        checks++;
        if (cap[0] !== 8'h03) begin errors++; $display("FAIL mode0_mosi_addr got %h want 03", cap[0]); end
        checks++;
        if (rises[0] !== 16 || edges[0] !== 32) begin
            errors++; $display("FAIL mode0_sck_edges got rises=%0d edges=%0d want 16/32", rises[0], edges[0]);
        end
    endtask

    task automatic test_mode3;
        logic [7:0] rd;
        int lat;
        @(negedge clk);
        set_mode(1'b1, 1'b1);
        checks++;
        if (sck_v[0] !== 1'b1) begin errors++; $display("FAIL mode3_idle_before got %b want 1", sck_v[0]); end
        do_read(0, 8'h08, 1'b0, rd, lat);
        checks++;
        if (rd !== 8'h3C) begin errors++; $display("FAIL mode3_rdata got %h want 3c", rd); end
        checks++;
        if (cap[0] !== 8'h08 || rises[0] !== 16 || edges[0] !== 32) begin
            errors++;
            $display("FAIL mode3_bus got addr=%h rises=%0d edges=%0d want 08/16/32", cap[0], rises[0], edges[0]);
        end
        @(negedge clk);
        checks++;
        if (sck_v[0] !== 1'b1) begin errors++; $display("FAIL mode3_idle_after got %b want 1", sck_v[0]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] rd;
        int lat, extra;
        @(negedge clk);
        set_mode(1'b0, 1'b0);
        do_read(0, 8'h01, 1'b0, rd, lat);
        checks++;
        if (rd !== 8'h81) begin errors++; $display("FAIL b2b_first got %h want 81", rd); end
        @(negedge clk);
        do_read(0, 8'h02, 1'b1, rd, lat);
        checks++;
        if (rd !== 8'h42 || lat !== 69) begin
            errors++; $display("FAIL b2b_second got rdata=%h lat=%0d want 42 lat=69", rd, lat);
        end
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (done_v[0] === 1'b1 || ss_v[0] === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ignored_start got %0d active cycles want 0", extra); end
    endtask

    task automatic test_addr_check;
        logic [7:0] rd;
        int lat, act;
        logic [7:0] bad [2];
        bad[0] = 8'h00;
        bad[1] = 8'h09;
`ifdef SPI_READ_MASTER_ADDR_CHECK_EN
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            addr_s = bad[k];
            start_v[0] = 1'b1;
            @(negedge clk);
            start_v[0] = 1'b0;
            checks++;
            if (err_v[0] !== 1'b1 || ss_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL addr_reject_%h got err/ss/busy=%b want 100", bad[k],
                         {err_v[0], ss_v[0], busy_v[0]});
            end
            act = 0;
            repeat (80) begin
                @(negedge clk);
                if (ss_v[0] === 1'b1 || done_v[0] === 1'b1 || err_v[0] === 1'b1) act++;
            end
            checks++;
            if (act !== 0 || rdata0 !== 8'h42) begin
                errors++;
                $display("FAIL addr_reject_quiet_%h got act=%0d rdata=%h want 0 42", bad[k], act, rdata0);
            end
        end
        checks++;
        if (err_cnt !== 2) begin errors++; $display("FAIL err_pulse_count got %0d want 2", err_cnt); end
`else
        @(negedge clk);
        do_read(0, bad[1], 1'b0, rd, lat);
        checks++;
        if (rd !== 8'h5A || lat !== 69 || edges[0] !== 32 || cap[0] !== 8'h09) begin
            errors++;
            $display("FAIL addr09_transfer got rdata=%h lat=%0d edges=%0d addr=%h want 5a 69 32 09",
                     rd, lat, edges[0], cap[0]);
        end
        checks++;
        if (err_cnt !== 0) begin errors++; $display("FAIL err_tied got %0d pulses want 0", err_cnt); end
`endif
    endtask

    task automatic test_clkdiv1;
        logic [7:0] rd;
        int lat;
        logic [7:0] a [4];
        logic [7:0] exp_d [4];
        a[0] = 8'h03; a[1] = 8'h06; a[2] = 8'h07; a[3] = 8'h08;
        exp_d[0] = 8'hA5; exp_d[1] = 8'h66; exp_d[2] = 8'hC3; exp_d[3] = 8'h3C;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            set_mode(m[1], m[0]);
            do_read(1, a[m], 1'b0, rd, lat);
            checks++;
            if (rd !== exp_d[m] || lat !== 35) begin
                errors++;
                $display("FAIL div1_mode%0d got rdata=%h lat=%0d want %h lat=35", m, rd, lat, exp_d[m]);
            end
            checks++;
            if (edges[1] !== 32 || cap[1] !== a[m]) begin
                errors++;
                $display("FAIL div1_bus_mode%0d got edges=%0d addr=%h want 32 %h", m, edges[1], cap[1], a[m]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mode0;
        test_mode3;
        test_back_to_back;
        test_addr_check;
        test_clkdiv1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
